// File: rtl/ex_mem_if.sv
// Bundle of EX-side inputs, data-memory port and MEM/WB outputs for ex_mem_stage.
// The master modport is the stage itself; slave is the surrounding pipeline/memory view.
interface ex_mem_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic               ex_valid;
  logic               ex_RegWrite;
  logic               ex_MemtoReg;
  logic               ex_Branch;
  logic               ex_MemRead;
  logic               ex_MemWrite;
  logic               ex_Zero;
  logic [DATA_W-1:0]  ex_ALUResult;
  logic [DATA_W-1:0]  ex_ALUAddResult;
  logic [DATA_W-1:0]  ex_ReadData2;
  logic [RADDR_W-1:0] ex_WriteReg;
  logic               ex_stall;

  logic               PCSrc;
  logic [DATA_W-1:0]  BranchTarget;

  logic               dmem_req;
  logic               dmem_we;
  logic [DATA_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_gnt;
  logic               dmem_rvalid;
  logic [DATA_W-1:0]  dmem_rdata;

  logic               wb_valid;
  logic               wb_RegWrite;
  logic               wb_MemtoReg;
  logic [DATA_W-1:0]  wb_ReadData;
  logic [DATA_W-1:0]  wb_ALUResult;
  logic [RADDR_W-1:0] wb_WriteReg;
  logic               mem_fault;

  modport master (
    input  ex_valid, ex_RegWrite, ex_MemtoReg, ex_Branch, ex_MemRead, ex_MemWrite, ex_Zero,
           ex_ALUResult, ex_ALUAddResult, ex_ReadData2, ex_WriteReg,
           dmem_gnt, dmem_rvalid, dmem_rdata,
    output ex_stall, PCSrc, BranchTarget,
           dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_RegWrite, wb_MemtoReg, wb_ReadData, wb_ALUResult, wb_WriteReg, mem_fault
  );

  modport slave (
    output ex_valid, ex_RegWrite, ex_MemtoReg, ex_Branch, ex_MemRead, ex_MemWrite, ex_Zero,
           ex_ALUResult, ex_ALUAddResult, ex_ReadData2, ex_WriteReg,
           dmem_gnt, dmem_rvalid, dmem_rdata,
    input  ex_stall, PCSrc, BranchTarget,
           dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_RegWrite, wb_MemtoReg, wb_ReadData, wb_ALUResult, wb_WriteReg, mem_fault
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus MEM-stage controller driving a req/gnt/rvalid data port.
// Holds EX while a memory access is outstanding, resolves branches and loads MEM/WB on completion.
module ex_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic     Clk,
  input  logic     Reset,
  ex_mem_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_to_reg;
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               zero;
    logic [DATA_W-1:0]  alu_result;
    logic [DATA_W-1:0]  add_result;
    logic [DATA_W-1:0]  store_data;
    logic [RADDR_W-1:0] write_reg;
  } exmem_t;

  state_e             state_q, state_d;
  exmem_t             exmem_q, exmem_d;

  logic               mem_op;
  logic               misaligned;
  logic               is_load;
  logic               complete;
  logic               stall;
  logic               in_aligned_mem;

  logic               wb_valid_q;
  logic               wb_reg_write_q;
  logic               wb_mem_to_reg_q;
  logic               mem_fault_q;
  logic [DATA_W-1:0]  wb_read_data_q;
  logic [DATA_W-1:0]  wb_alu_result_q;
  logic [RADDR_W-1:0] wb_write_reg_q;

  always_comb begin
    // NOTE: every always_comb output is assigned a default before any branch so no latch is inferred.
    exmem_d = exmem_q;
    state_d = state_q;

    mem_op     = exmem_q.valid & (exmem_q.mem_read | exmem_q.mem_write);
    misaligned = mem_op & (exmem_q.alu_result[1:0] != 2'b00);
    // Read and write both set behaves as a load.
    is_load    = exmem_q.mem_read;

    complete = exmem_q.valid & (~mem_op | misaligned
                              | ((state_q == S_REQ)  & bus.dmem_gnt & ~is_load)
                              | ((state_q == S_WAIT) & bus.dmem_rvalid));
    stall    = exmem_q.valid & ~complete;

    in_aligned_mem = bus.ex_valid & (bus.ex_MemRead | bus.ex_MemWrite)
                   & (bus.ex_ALUResult[1:0] == 2'b00);

    if (!stall) begin
      exmem_d.valid      = bus.ex_valid;
      exmem_d.reg_write  = bus.ex_RegWrite;
      exmem_d.mem_to_reg = bus.ex_MemtoReg;
      exmem_d.branch     = bus.ex_Branch;
      exmem_d.mem_read   = bus.ex_MemRead;
      exmem_d.mem_write  = bus.ex_MemWrite;
      exmem_d.zero       = bus.ex_Zero;
      exmem_d.alu_result = bus.ex_ALUResult;
      exmem_d.add_result = bus.ex_ALUAddResult;
      exmem_d.store_data = bus.ex_ReadData2;
      exmem_d.write_reg  = bus.ex_WriteReg;
      // An aligned access goes straight to REQ so the request issues the next cycle.
      state_d = in_aligned_mem ? S_REQ : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   if (bus.dmem_gnt) state_d = S_WAIT;
        S_WAIT:  state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q         <= S_IDLE;
      exmem_q         <= '0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_write_reg_q  <= '0;
      mem_fault_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q     <= state_d;
      exmem_q     <= exmem_d;
      wb_valid_q  <= complete;
      mem_fault_q <= complete & misaligned;
      if (complete) begin
        wb_reg_write_q  <= exmem_q.reg_write & ~misaligned;
        wb_mem_to_reg_q <= exmem_q.mem_to_reg;
        wb_alu_result_q <= exmem_q.alu_result;
        wb_write_reg_q  <= exmem_q.write_reg;
        wb_read_data_q  <= (state_q == S_WAIT) ? bus.dmem_rdata : '0;
      end
    end
  end

  assign bus.ex_stall     = stall;
  assign bus.PCSrc        = exmem_q.valid & exmem_q.branch & exmem_q.zero & complete;
  assign bus.BranchTarget = exmem_q.add_result;

  assign bus.dmem_req     = (state_q == S_REQ);
  assign bus.dmem_we      = (state_q == S_REQ) & ~is_load;
  assign bus.dmem_addr    = exmem_q.alu_result;
  assign bus.dmem_wdata   = exmem_q.store_data;

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_RegWrite  = wb_reg_write_q;
  assign bus.wb_MemtoReg  = wb_mem_to_reg_q;
  assign bus.wb_ReadData  = wb_read_data_q;
  assign bus.wb_ALUResult = wb_alu_result_q;
  assign bus.wb_WriteReg  = wb_write_reg_q;
  assign bus.mem_fault    = mem_fault_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random instructions against a
// transaction-level model (expected latency and writeback contents per instruction).
module tb_ex_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_if #(.DATA_W(DW), .RADDR_W(RW)) ifc ();

  ex_mem_stage #(.DATA_W(DW), .RADDR_W(RW)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (ifc)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          rw, mtr, br, mr, mw, zero;
    logic [DW-1:0] alu, add, wd;
    logic [RW-1:0] wr;
  } instr_t;

  // Memory responder: grants gnt_dly cycles after req rises, returns load data rv_dly cycles after gnt.
  int            gnt_dly  = 0;
  int            rv_dly   = 1;
  logic [DW-1:0] rd_val   = '0;
  bit            resp_en  = 1'b0;
  bit            force_rv = 1'b0;
  bit            stray_en = 1'b0;
  int            waited   = 0;
  int            rcount   = 0;
  bit            gnt_load = 1'b0;

  initial begin
    ifc.dmem_gnt    = 1'b0;
    ifc.dmem_rvalid = 1'b0;
    ifc.dmem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        ifc.dmem_gnt    = 1'b0;
        ifc.dmem_rvalid = force_rv;
        ifc.dmem_rdata  = 32'hBAD0_0BAD;
        waited = 0;
        rcount = 0;
      end else begin
        ifc.dmem_rvalid = 1'b0;
        if (ifc.dmem_gnt) begin
          ifc.dmem_gnt = 1'b0;
          waited = 0;
          if (gnt_load) rcount = 1;
        end else if (rcount != 0) begin
          rcount++;
        end
        if (rcount != 0 && rcount == rv_dly) begin
          ifc.dmem_rvalid = 1'b1;
          ifc.dmem_rdata  = rd_val;
          rcount = 0;
        end else if (stray_en && rcount == 0 && !ifc.dmem_req && $urandom_range(3) == 0) begin
          ifc.dmem_rvalid = 1'b1;
          ifc.dmem_rdata  = $urandom;
        end
        if (ifc.dmem_req) begin
          if (waited == gnt_dly) begin
            ifc.dmem_gnt = 1'b1;
            gnt_load     = !ifc.dmem_we;
          end else begin
            waited++;
          end
        end
      end
    end
  end

  task automatic drive_ex(input instr_t in, input logic v);
    ifc.ex_valid        = v;
    ifc.ex_RegWrite     = in.rw;
    ifc.ex_MemtoReg     = in.mtr;
    ifc.ex_Branch       = in.br;
    ifc.ex_MemRead      = in.mr;
    ifc.ex_MemWrite     = in.mw;
    ifc.ex_Zero         = in.zero;
    ifc.ex_ALUResult    = in.alu;
    ifc.ex_ALUAddResult = in.add;
    ifc.ex_ReadData2    = in.wd;
    ifc.ex_WriteReg     = in.wr;
  endtask

  function automatic instr_t blank();
    instr_t t;
    t.rw = 0; t.mtr = 0; t.br = 0; t.mr = 0; t.mw = 0; t.zero = 0;
    t.alu = '0; t.add = '0; t.wd = '0; t.wr = '0;
    return t;
  endfunction

  // Issues one instruction into an idle stage and checks every cycle until one past writeback.
  task automatic run_instr(input string name, input instr_t in, input int gd, input int rd,
                           input logic [DW-1:0] rdat);
    bit            memop, mis, amem, load, e_req, e_pc, e_wbv;
    int            lat;
    logic [DW-1:0] e_rdata;
    memop   = in.mr | in.mw;
    mis     = memop && (in.alu[1:0] != 2'b00);
    amem    = memop && !mis;
    load    = in.mr;
    lat     = 1 + (amem ? gd + (load ? rd : 0) : 0);
    e_rdata = (amem && load) ? rdat : '0;
    gnt_dly = gd;
    rv_dly  = rd;
    rd_val  = rdat;
    @(posedge clk); #1;
    drive_ex(in, 1'b1);
    @(posedge clk); #1;
    ifc.ex_valid = 1'b0;
    for (int j = 0; j <= lat + 1; j++) begin
      @(negedge clk);
      e_req = amem && (j <= gd);
      e_pc  = (j == lat - 1) && in.br && in.zero;
      e_wbv = (j == lat);
      checks++;
      if (ifc.ex_stall !== (j < lat - 1)) begin
        errors++;
        $display("FAIL %s ex_stall cyc=%0d got=%b exp=%b", name, j, ifc.ex_stall, (j < lat - 1));
      end
      checks++;
      if (ifc.dmem_req !== e_req || ifc.dmem_we !== (e_req && !load)) begin
        errors++;
        $display("FAIL %s req/we cyc=%0d got=%b/%b exp=%b/%b", name, j, ifc.dmem_req, ifc.dmem_we,
                 e_req, e_req && !load);
      end
      if (e_req) begin
        checks++;
        if (ifc.dmem_addr !== in.alu || (!load && ifc.dmem_wdata !== in.wd)) begin
          errors++;
          $display("FAIL %s addr/wdata cyc=%0d got=%h/%h exp=%h/%h", name, j, ifc.dmem_addr,
                   ifc.dmem_wdata, in.alu, in.wd);
        end
      end
      checks++;
      if (ifc.PCSrc !== e_pc || (e_pc && ifc.BranchTarget !== in.add)) begin
        errors++;
        $display("FAIL %s PCSrc cyc=%0d got=%b tgt=%h exp=%b tgt=%h", name, j, ifc.PCSrc,
                 ifc.BranchTarget, e_pc, in.add);
      end
      checks++;
      if (ifc.wb_valid !== e_wbv || ifc.mem_fault !== (e_wbv && mis)) begin
        errors++;
        $display("FAIL %s wb_valid/mem_fault cyc=%0d got=%b/%b exp=%b/%b", name, j, ifc.wb_valid,
                 ifc.mem_fault, e_wbv, e_wbv && mis);
      end
      if (e_wbv) begin
        checks++;
        if (ifc.wb_RegWrite !== (in.rw && !mis) || ifc.wb_MemtoReg !== in.mtr ||
            ifc.wb_ALUResult !== in.alu || ifc.wb_WriteReg !== in.wr || ifc.wb_ReadData !== e_rdata) begin
          errors++;
          $display("FAIL %s wb fields got rw=%b m2r=%b alu=%h wr=%0d rd=%h exp rw=%b m2r=%b alu=%h wr=%0d rd=%h",
                   name, ifc.wb_RegWrite, ifc.wb_MemtoReg, ifc.wb_ALUResult, ifc.wb_WriteReg,
                   ifc.wb_ReadData, in.rw && !mis, in.mtr, in.alu, in.wr, e_rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    drive_ex(blank(), 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.dmem_req, ifc.dmem_we, ifc.ex_stall, ifc.PCSrc, ifc.wb_valid, ifc.wb_RegWrite,
         ifc.wb_MemtoReg, ifc.mem_fault} !== 8'h00 || ifc.wb_ALUResult !== '0 ||
        ifc.wb_ReadData !== '0 || ifc.wb_WriteReg !== '0 || ifc.dmem_addr !== '0) begin
      errors++;
      $display("FAIL reset_state outputs not all zero: req=%b stall=%b wbv=%b alu=%h", ifc.dmem_req,
               ifc.ex_stall, ifc.wb_valid, ifc.wb_ALUResult);
    end
    rst_n   = 1'b1;
    resp_en = 1'b1;
  endtask

  task automatic test_alu();
    instr_t t = blank();
    t.alu = 32'h10; t.wr = 5'd5; t.rw = 1'b1;
    run_instr("alu_add", t, 0, 1, '0);
  endtask

  task automatic test_load();
    instr_t t = blank();
    t.alu = 32'h40; t.wr = 5'd9; t.rw = 1'b1; t.mtr = 1'b1; t.mr = 1'b1;
    run_instr("load_slow", t, 2, 3, 32'hDEADBEEF);
  endtask

  task automatic test_store();
    instr_t t = blank();
    t.alu = 32'h44; t.wd = 32'h1234; t.mw = 1'b1;
    run_instr("store_fast", t, 0, 1, '0);
  endtask

  task automatic test_branch();
    instr_t t = blank();
    t.br = 1'b1; t.zero = 1'b1; t.add = 32'h200;
    run_instr("beq_taken", t, 0, 1, '0);
    t.zero = 1'b0;
    run_instr("beq_not_taken", t, 0, 1, '0);
  endtask

  task automatic test_misaligned();
    instr_t t = blank();
    t.alu = 32'h41; t.wr = 5'd3; t.rw = 1'b1; t.mtr = 1'b1; t.mr = 1'b1;
    run_instr("load_misaligned", t, 0, 1, 32'h5555AAAA);
    t = blank();
    t.alu = 32'h46; t.wd = 32'hCAFE; t.mw = 1'b1;
    run_instr("store_misaligned", t, 0, 1, '0);
  endtask

  task automatic test_reset_mid_access();
    instr_t t = blank();
    t.alu = 32'h80; t.wr = 5'd7; t.rw = 1'b1; t.mtr = 1'b1; t.mr = 1'b1;
    gnt_dly = 0; rv_dly = 6; rd_val = 32'h0BADF00D;
    @(posedge clk); #1;
    drive_ex(t, 1'b1);
    @(posedge clk); #1;
    ifc.ex_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc.dmem_req !== 1'b0 || ifc.ex_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid waiting got req=%b stall=%b exp req=0 stall=1", ifc.dmem_req, ifc.ex_stall);
    end
    resp_en  = 1'b0;
    force_rv = 1'b1;
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({ifc.dmem_req, ifc.dmem_we, ifc.ex_stall, ifc.PCSrc, ifc.wb_valid, ifc.mem_fault} !== 6'h00 ||
        ifc.wb_ALUResult !== '0 || ifc.wb_ReadData !== '0) begin
      errors++;
      $display("FAIL rst_mid async outputs not zero: req=%b stall=%b wbv=%b", ifc.dmem_req,
               ifc.ex_stall, ifc.wb_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (ifc.wb_valid !== 1'b0 || ifc.ex_stall !== 1'b0 || ifc.dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid late rvalid cyc=%0d got wbv=%b stall=%b req=%b exp 0/0/0", j,
                 ifc.wb_valid, ifc.ex_stall, ifc.dmem_req);
      end
    end
    force_rv = 1'b0;
    resp_en  = 1'b1;
    run_instr("load_after_reset", t, 1, 2, 32'h600DD00D);
  endtask

  // Load then store held upstream: the store must request the cycle the load writes back.
  task automatic test_back_to_back();
    instr_t a = blank();
    instr_t b = blank();
    bit b_pending, e_req, e_wbv;
    a.alu = 32'h80; a.wr = 5'd12; a.rw = 1'b1; a.mtr = 1'b1; a.mr = 1'b1;
    b.alu = 32'h84; b.wd = 32'h7777_0001; b.mw = 1'b1;
    gnt_dly = 1; rv_dly = 2; rd_val = 32'hA5A5_1234;
    @(posedge clk); #1;
    drive_ex(a, 1'b1);
    @(posedge clk); #1;
    drive_ex(b, 1'b1);
    b_pending = 1'b1;
    // Load latency 1+1+2=4, store follows at 4+1+1=6.
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      e_req = (j <= 1) || (j == 4) || (j == 5);
      e_wbv = (j == 4) || (j == 6);
      checks++;
      if (ifc.dmem_req !== e_req || (e_req && ifc.dmem_addr !== ((j <= 1) ? a.alu : b.alu))) begin
        errors++;
        $display("FAIL b2b req cyc=%0d got req=%b addr=%h exp req=%b", j, ifc.dmem_req,
                 ifc.dmem_addr, e_req);
      end
      checks++;
      if (ifc.wb_valid !== e_wbv) begin
        errors++;
        $display("FAIL b2b wb_valid cyc=%0d got=%b exp=%b", j, ifc.wb_valid, e_wbv);
      end
      if (j == 4 || j == 6) begin
        checks++;
        if (ifc.wb_ALUResult !== ((j == 4) ? a.alu : b.alu) ||
            ifc.wb_ReadData !== ((j == 4) ? rd_val : '0) || ifc.wb_RegWrite !== (j == 4)) begin
          errors++;
          $display("FAIL b2b wb cyc=%0d got alu=%h rd=%h rw=%b", j, ifc.wb_ALUResult,
                   ifc.wb_ReadData, ifc.wb_RegWrite);
        end
      end
      if (b_pending && !ifc.ex_stall) begin
        @(posedge clk); #1;
        ifc.ex_valid = 1'b0;
        b_pending    = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    instr_t t;
    int     kind;
    stray_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      t      = blank();
      kind   = $urandom_range(5);
      t.rw   = $urandom_range(1);
      t.mtr  = $urandom_range(1);
      t.zero = $urandom_range(1);
      t.alu  = {$urandom} & ~32'h3;
      t.add  = $urandom;
      t.wd   = $urandom;
      t.wr   = RW'($urandom);
      case (kind)
        1: t.br = 1'b1;
        2: t.mr = 1'b1;
        3: t.mw = 1'b1;
        4: begin
          t.mr  = $urandom_range(1);
          t.mw  = ~t.mr;
          t.alu = t.alu | 32'($urandom_range(1, 3));
        end
        5: begin
          t.mr = 1'b1;
          t.mw = 1'b1;
        end
        default: ;
      endcase
      run_instr("random", t, $urandom_range(3), $urandom_range(1, 3), $urandom);
    end
    stray_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
